// File: rtl/port_backend.sv
`timescale 1ns/1ps
// port_backend: per-port egress stage; picks a priority queue (strict or WRR), requests one packet, buffers it in a halfword FIFO.
// Latency: a halfword written into an empty FIFO is presented on rd_vld/rd_data in the following cycle.
// Backpressure: ready low holds the head beat stable; registered in_stall asks the controller to pause near full.
// Optional: define PORT_BACKEND_STATS_EN to add the pkt_cnt/beat_cnt statistics outputs.
module port_backend #(
    parameter int FIFO_DEPTH   = 16,
    parameter int STALL_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrr_en,
    input  logic [7:0]  queue_not_empty,
    output logic        pkt_req,
    output logic [2:0]  pkt_req_prior,
    input  logic        pkt_grant,
    input  logic        in_vld,
    input  logic [15:0] in_data,
    input  logic        in_eop,
    output logic        in_stall,
    input  logic        ready,
    output logic        rd_sop,
    output logic        rd_eop,
    output logic        rd_vld,
    output logic [15:0] rd_data,
`ifdef PORT_BACKEND_STATS_EN
    output logic [15:0] pkt_cnt,
    output logic [31:0] beat_cnt,
`endif
    output logic        err_ovf
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     STALL_LVL = (AW+1)'(FIFO_DEPTH - STALL_MARGIN);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  req_prior;
    logic        req_wrr;
    logic [2:0]  rr_ptr;
    logic [3:0]  credit [8];
    logic        first_beat;
    logic        any_ne;

    logic [2:0]  sp_sel;
    logic [2:0]  wrr_sel;
    logic [2:0]  wrr_idx;
    logic        wrr_move;

    // FIFO storage: each entry is {eop, sop, data}
    logic [17:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    fifo_cnt, fifo_cnt_nxt;
    logic           fifo_empty, fifo_full;
    logic           push_vld, push_ok, pop_ok, push_drop;
    logic [17:0]    push_dat, head_dat;

    assign any_ne = |queue_not_empty;

    // Queue selection for both modes; WRR hops downward when the pointer's queue is empty or out of credit
    always_comb begin
        sp_sel   = 3'd0;
        wrr_sel  = rr_ptr;
        wrr_idx  = rr_ptr;
        wrr_move = !(queue_not_empty[rr_ptr] && (credit[rr_ptr] != 4'd0));
        for (int q = 0; q < 8; q++) begin
            if (queue_not_empty[q]) sp_sel = 3'(q);
        end
        if (wrr_move) begin
            // k = 8 wraps back to rr_ptr itself, so a lone queue is re-served with fresh credit
            for (int k = 8; k >= 1; k--) begin
                wrr_idx = rr_ptr - 3'(k);
                if (queue_not_empty[wrr_idx]) wrr_sel = wrr_idx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; pkt_req is a pure function of the REQ state
    always_comb begin
        state_nxt = state;
        pkt_req   = 1'b0;
        case (state)
            IDLE: if (any_ne) state_nxt = REQ;
            REQ: begin
                pkt_req = 1'b1;
                if (pkt_grant)                         state_nxt = XFER;
                else if (!queue_not_empty[req_prior])  state_nxt = IDLE;
            end
            XFER: if (in_vld && in_eop) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pkt_req_prior = req_prior;

    // Selection latch, WRR credit/pointer bookkeeping, sop tracking and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prior  <= 3'd0;
            req_wrr    <= 1'b0;
            rr_ptr     <= 3'd7;
            first_beat <= 1'b0;
            err_ovf    <= 1'b0;
            for (int q = 0; q < 8; q++) credit[q] <= 4'(q + 1);
        end else begin
            if (state == IDLE && any_ne) begin
                req_wrr <= wrr_en;
                if (wrr_en) begin
                    req_prior <= wrr_sel;
                    if (wrr_move) begin
                        credit[rr_ptr] <= 4'(rr_ptr) + 4'd1;
                        rr_ptr         <= wrr_sel;
                    end
                end else begin
                    req_prior <= sp_sel;
                end
            end
            if (state == REQ && pkt_grant)        first_beat <= 1'b1;
            else if (state == XFER && in_vld)     first_beat <= 1'b0;
            if (state == DONE && req_wrr && credit[req_prior] != 4'd0)
                credit[req_prior] <= credit[req_prior] - 4'd1;
            if (push_drop) err_ovf <= 1'b1;
        end
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_LVL);
    assign push_vld   = (state == XFER) && in_vld;
    assign push_dat   = {in_eop, first_beat, in_data};
    assign pop_ok     = ready && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign push_ok    = push_vld && (!fifo_full || pop_ok);
    assign push_drop  = push_vld && fifo_full && !pop_ok;

    // Occupancy next value from the push/pop pair
    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push_ok && !pop_ok)      fifo_cnt_nxt = fifo_cnt + (AW+1)'(1);
        else if (!push_ok && pop_ok) fifo_cnt_nxt = fifo_cnt - (AW+1)'(1);
    end

    // FIFO pointers, occupancy and the registered stall request
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            in_stall <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt_nxt;
            in_stall <= (fifo_cnt_nxt >= STALL_LVL);
        end
    end

    // FIFO storage write; contents need no reset since the occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_dat;
    end

    assign head_dat = fifo_mem[rd_ptr];
    assign rd_vld   = !fifo_empty;
    assign rd_data  = fifo_empty ? 16'd0 : head_dat[15:0];
    assign rd_sop   = !fifo_empty && head_dat[16];
    assign rd_eop   = !fifo_empty && head_dat[17];

`ifdef PORT_BACKEND_STATS_EN
    // Popped beat and packet counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= 16'd0;
            beat_cnt <= 32'd0;
        end else if (pop_ok) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (head_dat[17]) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_port_backend.sv
`timescale 1ns/1ps
// tb_port_backend: directed checks of selection, FIFO flow control, overflow, withdraw and reset flush.
// Latency: outputs sampled 1 ns after each rising edge; popped beats recorded just before the edge.
// Backpressure: ready driven per test; in_stall honoured or deliberately ignored.
module tb_port_backend;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrr_en;
    logic [7:0]  queue_not_empty;
    logic        pkt_req;
    logic [2:0]  pkt_req_prior;
    logic        pkt_grant;
    logic        in_vld;
    logic [15:0] in_data;
    logic        in_eop;
    logic        in_stall;
    logic        ready;
    logic        rd_sop;
    logic        rd_eop;
    logic        rd_vld;
    logic [15:0] rd_data;
    logic        err_ovf;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] got_q[$];

    always #5 clk = ~clk;

    port_backend #(.FIFO_DEPTH(16), .STALL_MARGIN(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .wrr_en          (wrr_en),
        .queue_not_empty (queue_not_empty),
        .pkt_req         (pkt_req),
        .pkt_req_prior   (pkt_req_prior),
        .pkt_grant       (pkt_grant),
        .in_vld          (in_vld),
        .in_data         (in_data),
        .in_eop          (in_eop),
        .in_stall        (in_stall),
        .ready           (ready),
        .rd_sop          (rd_sop),
        .rd_eop          (rd_eop),
        .rd_vld          (rd_vld),
        .rd_data         (rd_data),
        .err_ovf         (err_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] beat(input logic eop, input logic sop, input logic [15:0] d);
        return {eop, sop, d};
    endfunction

    // One clock: record the beat that pops on this edge, then settle 1 ns past the edge
    task automatic step();
        if (rd_vld && ready) got_q.push_back({rd_eop, rd_sop, rd_data});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pkt_grant = 1'b0; in_vld = 1'b0; in_eop = 1'b0;
        queue_not_empty = 8'h00;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!pkt_req && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(pkt_req), 32'd1);
    endtask

    task automatic grant();
        pkt_grant = 1'b1;
        step();
        pkt_grant = 1'b0;
    endtask

    task automatic push_beat(input logic [15:0] d, input logic eop);
        in_vld = 1'b1; in_data = d; in_eop = eop;
        step();
        in_vld = 1'b0; in_eop = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ready = 1'b1;
        while (rd_vld && n < 60) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(rd_vld), 32'd0);
    endtask

    initial begin
        int exp_q [$];
        int n;
        logic [15:0] base;

        rst = 1'b1; wrr_en = 1'b0; queue_not_empty = 8'h00; pkt_grant = 1'b0;
        in_vld = 1'b0; in_data = 16'h0; in_eop = 1'b0; ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_pkt_req",   32'(pkt_req),       32'd0);
        chk("rst_prior",     32'(pkt_req_prior), 32'd0);
        chk("rst_rd_vld",    32'(rd_vld),        32'd0);
        chk("rst_rd_sop",    32'(rd_sop),        32'd0);
        chk("rst_rd_eop",    32'(rd_eop),        32'd0);
        chk("rst_rd_data",   32'(rd_data),       32'd0);
        chk("rst_in_stall",  32'(in_stall),      32'd0);
        chk("rst_err_ovf",   32'(err_ovf),       32'd0);

        // Strict priority with a 3-beat packet
        wrr_en = 1'b0; ready = 1'b1; queue_not_empty = 8'b0010_0101;
        step();
        chk("sp_req",        32'(pkt_req),       32'd1);
        chk("sp_prior5",     32'(pkt_req_prior), 32'd5);
        grant();
        chk("sp_req_drop",   32'(pkt_req),       32'd0);
        push_beat(16'hA001, 1'b0);
        chk("sp_lat_vld",    32'(rd_vld),        32'd1);
        chk("sp_lat_sop",    32'(rd_sop),        32'd1);
        chk("sp_lat_data",   32'(rd_data),       32'hA001);
        push_beat(16'hA002, 1'b0);
        push_beat(16'hA003, 1'b1);
        queue_not_empty = 8'b0000_0101;
        chk("sp_done_req",   32'(pkt_req),       32'd0);
        step();
        chk("sp_idle_req",   32'(pkt_req),       32'd0);
        step();
        chk("sp_next_req",   32'(pkt_req),       32'd1);
        chk("sp_prior2",     32'(pkt_req_prior), 32'd2);
        chk("sp_nbeats",     32'(got_q.size()),  32'd3);
        if (got_q.size() == 3) begin
            chk("sp_beat0", 32'(got_q[0]), 32'(beat(1'b0, 1'b1, 16'hA001)));
            chk("sp_beat1", 32'(got_q[1]), 32'(beat(1'b0, 1'b0, 16'hA002)));
            chk("sp_beat2", 32'(got_q[2]), 32'(beat(1'b1, 1'b0, 16'hA003)));
        end

        // WRR across all queues: 8 from q7 down to 1 from q0, then q7 again
        do_reset();
        wrr_en = 1'b1; ready = 1'b1; queue_not_empty = 8'hFF;
        exp_q.delete();
        for (int q = 7; q >= 0; q--)
            for (int r = 0; r <= q; r++) exp_q.push_back(q);
        exp_q.push_back(7);
        for (int p = 0; p < 37; p++) begin
            wait_req("wrr");
            chk("wrr_seq", 32'(pkt_req_prior), 32'(exp_q[p]));
            grant();
            push_beat(16'(p), 1'b1);
        end

        // Withdraw in REQ leaves credit[3] intact: four q3 packets, then q2
        do_reset();
        wrr_en = 1'b1; ready = 1'b1; queue_not_empty = 8'b0000_1000;
        step();
        chk("wd_req",        32'(pkt_req),       32'd1);
        chk("wd_prior3",     32'(pkt_req_prior), 32'd3);
        queue_not_empty = 8'h00;
        step();
        chk("wd_req_drop",   32'(pkt_req),       32'd0);
        step();
        chk("wd_idle",       32'(pkt_req),       32'd0);
        queue_not_empty = 8'b0000_1100;
        for (int p = 0; p < 5; p++) begin
            wait_req("wd");
            chk("wd_seq", 32'(pkt_req_prior), (p < 4) ? 32'd3 : 32'd2);
            grant();
            push_beat(16'(p), 1'b1);
        end

        // Backpressure: stall at 12 entries, honour it, drain all 20 beats in order
        do_reset();
        wrr_en = 1'b0; ready = 1'b0; queue_not_empty = 8'h01; base = 16'hB000;
        wait_req("bp");
        grant();
        for (int i = 0; i < 12; i++) begin
            push_beat(base + 16'(i), 1'b0);
            if (i == 10) chk("bp_stall_11", 32'(in_stall), 32'd0);
            if (i == 11) chk("bp_stall_12", 32'(in_stall), 32'd1);
        end
        chk("bp_hold_data",  32'(rd_data),       32'(base));
        chk("bp_hold_sop",   32'(rd_sop),        32'd1);
        ready = 1'b1;
        for (int i = 12; i < 20; i++) begin
            n = 0;
            while (in_stall && n < 50) begin
                step();
                n++;
            end
            if (in_stall) chk("bp_stall_stuck", 32'(in_stall), 32'd0);
            push_beat(base + 16'(i), i == 19);
        end
        queue_not_empty = 8'h00;
        drain();
        chk("bp_nbeats",     32'(got_q.size()),  32'd20);
        for (int i = 0; i < got_q.size() && i < 20; i++)
            chk("bp_beat", 32'(got_q[i]), 32'(beat(i == 19, i == 0, base + 16'(i))));
        chk("bp_no_ovf",     32'(err_ovf),       32'd0);

        // Overflow: ignore stall, 17 beats with ready low; the 17th is dropped
        do_reset();
        ready = 1'b0; queue_not_empty = 8'h01; base = 16'hC000;
        wait_req("ovf");
        grant();
        for (int i = 0; i < 17; i++) begin
            push_beat(base + 16'(i), i == 16);
            if (i == 15) chk("ovf_full_ok", 32'(err_ovf), 32'd0);
        end
        chk("ovf_set",       32'(err_ovf),       32'd1);
        queue_not_empty = 8'h00;
        drain();
        chk("ovf_nbeats",    32'(got_q.size()),  32'd16);
        if (got_q.size() == 16) begin
            chk("ovf_first", 32'(got_q[0]),  32'(beat(1'b0, 1'b1, base)));
            chk("ovf_last",  32'(got_q[15]), 32'(beat(1'b0, 1'b0, base + 16'd15)));
        end
        chk("ovf_sticky",    32'(err_ovf),       32'd1);

        // Reset mid-packet flushes everything, including the sticky overflow flag
        do_reset();
        chk("rst_clr_ovf",   32'(err_ovf),       32'd0);
        ready = 1'b0; queue_not_empty = 8'h01; base = 16'hD000;
        wait_req("mid");
        grant();
        for (int i = 0; i < 4; i++) push_beat(base + 16'(i), 1'b0);
        chk("mid_pre_vld",   32'(rd_vld),        32'd1);
        rst = 1'b1; in_vld = 1'b1; in_data = base + 16'd4;
        step();
        rst = 1'b0; queue_not_empty = 8'h00;
        chk("mid_rd_vld",    32'(rd_vld),        32'd0);
        chk("mid_pkt_req",   32'(pkt_req),       32'd0);
        chk("mid_in_stall",  32'(in_stall),      32'd0);
        chk("mid_err_ovf",   32'(err_ovf),       32'd0);
        ready = 1'b1; n = 0;
        for (int i = 5; i < 10; i++) begin
            push_beat(base + 16'(i), i == 9);
            if (rd_vld) n++;
        end
        chk("mid_no_beats",  32'(n),             32'd0);
        chk("mid_no_ovf",    32'(err_ovf),       32'd0);

        // Push and pop together while full: accepted, no overflow
        do_reset();
        ready = 1'b0; queue_not_empty = 8'h01; base = 16'hE000;
        wait_req("pp");
        grant();
        for (int i = 0; i < 16; i++) push_beat(base + 16'(i), 1'b0);
        chk("pp_full_noovf", 32'(err_ovf),       32'd0);
        ready = 1'b1;
        push_beat(base + 16'd16, 1'b1);
        chk("pp_noovf",      32'(err_ovf),       32'd0);
        queue_not_empty = 8'h00;
        drain();
        chk("pp_nbeats",     32'(got_q.size()),  32'd17);
        if (got_q.size() == 17)
            chk("pp_last", 32'(got_q[16]), 32'(beat(1'b1, 1'b0, base + 16'd16)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
